// File: rtl/vga_frame_capture.sv
// vga_frame_capture: VGA sink that rebuilds pixel coordinates from sync edges
// and writes one full frame to a buffer per request. Option macro: VGA_CAPTURE_DOWNSAMPLE_2X_EN.
module vga_frame_capture #(
   parameter int H_SYNC_CYC = 96,
   parameter int H_START    = 144,
   parameter int H_ACT      = 640,
   parameter int H_TOTAL    = 800,
   parameter int V_START    = 35,
   parameter int V_ACT      = 480,
   parameter int V_TOTAL    = 525
) (
   input  logic        iCLK,
   input  logic        iRST_N,
   input  logic [7:0]  iVGA_R,
   input  logic [7:0]  iVGA_G,
   input  logic [7:0]  iVGA_B,
   input  logic        iVGA_H_SYNC,
   input  logic        iVGA_V_SYNC,
   input  logic        iCapture_Req,
   output logic        oBusy,
   output logic        oWrite,
   output logic [19:0] oAddress,
   output logic [9:0]  oCoord_X,
   output logic [9:0]  oCoord_Y,
   output logic [23:0] oData,
   output logic        oFrame_Done,
   output logic        oSync_Err
);

   localparam logic [9:0] H_S     = 10'(H_START);
   localparam logic [9:0] H_E     = 10'(H_START + H_ACT);
   localparam logic [9:0] V_S     = 10'(V_START);
   localparam logic [9:0] V_E     = 10'(V_START + V_ACT);
   localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
   localparam logic [9:0] CNT_MAX = 10'h3FF;

   // hsync must end before the first active pixel and the active window must fit the totals
   if (H_SYNC_CYC >= H_START || H_START + H_ACT > H_TOTAL ||
       V_START + V_ACT > V_TOTAL) begin : g_bad_timing
      $error("vga_frame_capture: inconsistent timing parameters");
   end

   typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

   state_t      state;
   logic [23:0] pix1;
   logic [23:0] pix2;
   logic        hs1;
   logic        hs2;
   logic        vs1;
   logic        vs2;
   logic        req1;
   logic [9:0]  h_cnt;
   logic [9:0]  v_cnt;
   logic        line_seen;
   logic        frame_seen;
   logic        h_fall;
   logic        v_fall;
   logic [9:0]  x;
   logic [9:0]  y;
   logic        in_act;
   logic        wr_en;
   logic        last_px;
   logic [9:0]  cx;
   logic [9:0]  cy;
   logic [19:0] addr;

   assign h_fall = hs2 & ~hs1;
   assign v_fall = vs2 & ~vs1;

   // register every input once, syncs twice for edge detection
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         pix1 <= '0;
         hs1  <= 1'b0;
         hs2  <= 1'b0;
         vs1  <= 1'b0;
         vs2  <= 1'b0;
         req1 <= 1'b0;
      end else begin
         pix1 <= {iVGA_R, iVGA_G, iVGA_B};
         hs1  <= iVGA_H_SYNC;
         hs2  <= hs1;
         vs1  <= iVGA_V_SYNC;
         vs2  <= vs1;
         req1 <= iCapture_Req;
      end
   end

   // position counters, kept aligned with the pixel held in pix2
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         pix2  <= '0;
         h_cnt <= '0;
         v_cnt <= '0;
      end else begin
         pix2 <= pix1;
         if (h_fall)
            h_cnt <= '0;
         else if (h_cnt != CNT_MAX)
            h_cnt <= h_cnt + 10'd1;
         if (v_fall)
            v_cnt <= '0;
         else if (h_fall && v_cnt != CNT_MAX)
            v_cnt <= v_cnt + 10'd1;
      end
   end

   // active-window decode and frame-buffer address of the pixel in pix2
   always_comb begin
      x      = h_cnt - H_S;
      y      = v_cnt - V_S;
      in_act = (h_cnt >= H_S) && (h_cnt < H_E) &&
               (v_cnt >= V_S) && (v_cnt < V_E);
`ifdef VGA_CAPTURE_DOWNSAMPLE_2X_EN
      wr_en   = in_act && !x[0] && !y[0];
      cx      = {1'b0, x[9:1]};
      cy      = {1'b0, y[9:1]};
      addr    = 20'(cy) * 20'(H_ACT / 2) + 20'(cx);
      last_px = (x == 10'(H_ACT - 2)) && (y == 10'(V_ACT - 2));
`else
      wr_en   = in_act;
      cx      = x;
      cy      = y;
      addr    = 20'(cy) * 20'(H_ACT) + 20'(cx);
      last_px = (x == 10'(H_ACT - 1)) && (y == 10'(V_ACT - 1));
`endif
   end

   // capture FSM with registered write port, status and timing checks
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state       <= IDLE;
         oBusy       <= 1'b0;
         oWrite      <= 1'b0;
         oAddress    <= '0;
         oCoord_X    <= '0;
         oCoord_Y    <= '0;
         oData       <= '0;
         oFrame_Done <= 1'b0;
         oSync_Err   <= 1'b0;
         line_seen   <= 1'b0;
         frame_seen  <= 1'b0;
      end else begin
         oWrite      <= 1'b0;
         oFrame_Done <= 1'b0;
         oBusy       <= (state != IDLE);
         if (h_fall)
            line_seen <= 1'b1;
         if (v_fall)
            frame_seen <= 1'b1;
         if (h_fall && line_seen && h_cnt != H_LAST)
            oSync_Err <= 1'b1;
         if (v_fall && frame_seen && v_cnt != V_LAST)
            oSync_Err <= 1'b1;
         unique case (state)
            IDLE: begin
               if (req1) begin
                  state     <= ARMED;
                  oSync_Err <= 1'b0;
               end
            end
            ARMED: begin
               if (v_fall)
                  state <= CAPTURE;
            end
            CAPTURE: begin
               if (v_fall) begin
                  state     <= IDLE;
                  oSync_Err <= 1'b1;
               end else if (wr_en) begin
                  oWrite   <= 1'b1;
                  oAddress <= addr;
                  oCoord_X <= cx;
                  oCoord_Y <= cy;
                  oData    <= pix2;
                  if (last_px)
                     state <= DONE;
               end
            end
            DONE: begin
               oFrame_Done <= 1'b1;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vga_frame_capture.sv
// tb_vga_frame_capture: scaled-down VGA source with a scoreboard of
// expected frame-buffer writes for vga_frame_capture.
module tb_vga_frame_capture;

   localparam int HS    = 4;
   localparam int HST   = 6;
   localparam int HA    = 16;
   localparam int HT    = 24;
   localparam int VSL   = 2;
   localparam int VST   = 3;
   localparam int VA    = 8;
   localparam int VT    = 12;
   localparam int FRAME = HT * VT;
`ifdef VGA_CAPTURE_DOWNSAMPLE_2X_EN
   localparam bit DS = 1'b1;
`else
   localparam bit DS = 1'b0;
`endif
   localparam int NW = DS ? (HA * VA / 4) : (HA * VA);

   typedef struct packed {
      logic [19:0] a;
      logic [9:0]  x;
      logic [9:0]  y;
      logic [23:0] d;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  r;
   logic [7:0]  g;
   logic [7:0]  b;
   logic        hsync;
   logic        vsync;
   logic        req;
   logic        busy;
   logic        wr;
   logic [19:0] addr;
   logic [9:0]  cx;
   logic [9:0]  cy;
   logic [23:0] data;
   logic        done;
   logic        err;

   exp_t sb[$];
   int   checks;
   int   failures;
   int   cyc;
   int   nwr;
   int   ndone;
   int   last_wr;
   int   done_cyc;
   int   hc;
   int   vc;
   bit   short_req;
   int   short_line;
   bit   early_req;
   int   early_line;
   bit   exp_armed;
   bit   exp_cap;

   vga_frame_capture #(
      .H_SYNC_CYC(HS), .H_START(HST), .H_ACT(HA), .H_TOTAL(HT),
      .V_START(VST), .V_ACT(VA), .V_TOTAL(VT)
   ) dut (
      .iCLK(clk), .iRST_N(rst_n),
      .iVGA_R(r), .iVGA_G(g), .iVGA_B(b),
      .iVGA_H_SYNC(hsync), .iVGA_V_SYNC(vsync),
      .iCapture_Req(req), .oBusy(busy), .oWrite(wr),
      .oAddress(addr), .oCoord_X(cx), .oCoord_Y(cy),
      .oData(data), .oFrame_Done(done), .oSync_Err(err)
   );

   always #5 clk = ~clk;

   task automatic src_step();
      hc++;
      if (hc == HT || (short_req && vc == short_line && hc == HT - 1)) begin
         if (hc == HT - 1)
            short_req = 1'b0;
         hc = 0;
         vc++;
         if (vc == VT || (early_req && vc == early_line)) begin
            if (vc != VT)
               early_req = 1'b0;
            vc = 0;
            exp_cap = exp_armed;
            exp_armed = 1'b0;
         end
      end
   endtask

   task automatic src_drive();
      int   x;
      int   y;
      int   lx;
      exp_t e;
      x = hc - HST;
      y = vc - VST;
      lx = DS ? HA - 2 : HA - 1;
      hsync = (hc >= HS);
      vsync = (vc >= VSL);
      if (x >= 0 && x < HA && y >= 0 && y < VA) begin
         r = 8'(x);
         g = 8'(y);
         b = 8'hA5;
         if (exp_cap && (!DS || (x % 2 == 0 && y % 2 == 0))) begin
            if (DS)
               e = {20'((y / 2) * (HA / 2) + x / 2), 10'(x / 2), 10'(y / 2), r, g, b};
            else
               e = {20'(y * HA + x), 10'(x), 10'(y), r, g, b};
            sb.push_back(e);
            if (x == lx && y == (DS ? VA - 2 : VA - 1))
               exp_cap = 1'b0;
         end
      end else begin
         r = 8'h00;
         g = 8'h00;
         b = 8'h00;
      end
   endtask

   task automatic tick();
      exp_t e;
      @(negedge clk);
      cyc++;
      if (wr === 1'b1) begin
         nwr++;
         checks++;
         last_wr = cyc;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL write_unexpected got a=%0d x=%0d y=%0d want no write",
                     addr, cx, cy);
         end else begin
            e = sb.pop_front();
            if ({addr, cx, cy, data} !== e) begin
               failures++;
               $display("FAIL write_data got a=%0d x=%0d y=%0d d=%h want a=%0d x=%0d y=%0d d=%h",
                        addr, cx, cy, data, e.a, e.x, e.y, e.d);
            end
         end
      end
      if (done === 1'b1) begin
         ndone++;
         done_cyc = cyc;
         checks++;
         if (last_wr != cyc - 1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL done_timing got last_wr=%0d busy=%b want last_wr=%0d busy=1",
                     last_wr, busy, cyc - 1);
         end
      end
      if (cyc == done_cyc + 1) begin
         checks++;
         if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL busy_after_done got busy=%b done=%b want 0 0", busy, done);
         end
      end
      src_step();
      src_drive();
   endtask

   task automatic wait_line(input int l);
      int n;
      n = 0;
      while (!(vc == l && hc == 0) && n < 2 * FRAME + 4) begin
         tick();
         n++;
      end
      if (!(vc == l && hc == 0)) begin
         checks++;
         failures++;
         $display("FAIL wait_line got timeout want line %0d", l);
      end
   endtask

   task automatic wait_done(input int d0);
      int n;
      n = 0;
      while (ndone == d0 && n < 3 * FRAME) begin
         tick();
         n++;
      end
      checks++;
      if (ndone != d0 + 1) begin
         failures++;
         $display("FAIL frame_done_count got %0d want %0d", ndone, d0 + 1);
      end
      repeat (4) tick();
   endtask

   task automatic pulse_req();
      tick();
      req = 1'b1;
      if (!exp_cap && !exp_armed)
         exp_armed = 1'b1;
      tick();
      req = 1'b0;
   endtask

   task automatic test_reset();
      logic [67:0] o;
      int n0;
      for (int i = 0; i < 40; i++) begin
         tick();
         o = {wr, busy, done, err, addr, cx, cy, data};
         checks++;
         if (o !== '0) begin
            failures++;
            $display("FAIL reset_outputs got %h want 0", o);
         end
      end
      rst_n = 1'b1;
      n0 = nwr;
      repeat (2 * FRAME) tick();
      checks++;
      if (nwr != n0 || busy !== 1'b0 || err !== 1'b0) begin
         failures++;
         $display("FAIL idle_after_reset got wr=%0d busy=%b err=%b want 0 0 0",
                  nwr - n0, busy, err);
      end
   endtask

   task automatic test_full_frame();
      int n0;
      int d0;
      wait_line(VST + 2);
      n0 = nwr;
      d0 = ndone;
      pulse_req();
      repeat (3) tick();
      checks++;
      if (busy !== 1'b1 || nwr != n0) begin
         failures++;
         $display("FAIL armed got busy=%b wr=%0d want busy=1 wr=0", busy, nwr - n0);
      end
      wait_done(d0);
      checks++;
      if (nwr - n0 != NW || sb.size() != 0 || err !== 1'b0) begin
         failures++;
         $display("FAIL full_frame got wr=%0d q=%0d err=%b want wr=%0d q=0 err=0",
                  nwr - n0, sb.size(), err, NW);
      end
   endtask

   task automatic test_sync_err();
      int n0;
      int d0;
      wait_line(VST + 2);
      n0 = nwr;
      d0 = ndone;
      pulse_req();
      wait_line(1);
      short_line = VST + 3;
      short_req = 1'b1;
      wait_done(d0);
      checks++;
      if (err !== 1'b1 || nwr - n0 != NW || sb.size() != 0) begin
         failures++;
         $display("FAIL short_line got err=%b wr=%0d want err=1 wr=%0d",
                  err, nwr - n0, NW);
      end
   endtask

   task automatic test_back_to_back();
      int n0;
      int d0;
      wait_line(VST + 2);
      n0 = nwr;
      d0 = ndone;
      pulse_req();
      repeat (3) tick();
      checks++;
      if (err !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL err_clear got err=%b busy=%b want 0 1", err, busy);
      end
      wait_done(d0);
      checks++;
      if (err !== 1'b0 || nwr - n0 != NW) begin
         failures++;
         $display("FAIL second_frame got err=%b wr=%0d want 0 %0d", err, nwr - n0, NW);
      end
   endtask

   task automatic test_early_vsync();
      int n0;
      int d0;
      int want;
      wait_line(VST + 2);
      pulse_req();
      wait_line(VST + 1);
      n0 = nwr;
      d0 = ndone;
      pulse_req();
      early_line = VST + 4;
      early_req = 1'b1;
      wait_line(1);
      repeat (4) tick();
      want = DS ? HA / 2 : 3 * HA;
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || ndone != d0) begin
         failures++;
         $display("FAIL early_vsync got err=%b busy=%b done=%0d want 1 0 %0d",
                  err, busy, ndone, d0);
      end
      checks++;
      if (nwr - n0 != want || sb.size() != 0) begin
         failures++;
         $display("FAIL early_writes got %0d q=%0d want %0d q=0",
                  nwr - n0, sb.size(), want);
      end
      n0 = nwr;
      repeat (FRAME + 10) tick();
      checks++;
      if (nwr != n0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL no_restart got wr=%0d busy=%b want 0 0", nwr - n0, busy);
      end
   endtask

   task automatic test_reset_mid_capture();
      int n0;
      int n;
      wait_line(VST + 2);
      pulse_req();
      wait_line(VST + 2);
      n = 0;
      while (wr !== 1'b1 && n < HT) begin
         tick();
         n++;
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (wr !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL async_reset got wr=%b busy=%b want 0 0", wr, busy);
      end
      sb.delete();
      exp_cap = 1'b0;
      exp_armed = 1'b0;
      n0 = nwr;
      repeat (5) tick();
      rst_n = 1'b1;
      repeat (2 * FRAME) tick();
      checks++;
      if (nwr != n0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL after_reset got wr=%0d busy=%b want 0 0", nwr - n0, busy);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      req = 1'b0;
      hc = HT - 1;
      vc = VT - 1;
      last_wr = -10;
      done_cyc = -10;
      src_drive();
      test_reset();
      test_full_frame();
      test_sync_err();
      test_back_to_back();
      test_early_vsync();
      test_reset_mid_capture();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
